galois_mult_arbiter: RTL
========================

// Module: galois_mult_arbiter
// PURPOSE
//  Round-robin arbiter and sequencer that shares one Barrett GF(p) multiplier between NUM_REQ requesters.
//  - Accepts one operand pair per grant and drives the multiplier's rst/en/operand pins.
//  - Waits for the multiplier's done, then returns the product to the granted requester over a valid/ready channel.
//  - Sits between the MiMC round units and the single shared multiplier instance.
// PARAMETERS
//  N_BITS         254  field element width
//  NUM_REQ        4    number of requesters (>=2)
//  TIMEOUT_CYCLES 16   max cycles in WAIT before an error response (>=8)
// PORTS
//  clk          in   1                 clock, all logic on posedge
//  rst          in   1                 synchronous active-high reset
//  req_valid    in   NUM_REQ           per-requester operand valid
//  req_ready    out  NUM_REQ           one-hot accept pulse; handshake = valid & ready
//  req_a        in   NUM_REQ*N_BITS    operand 1, requester i at [i*N_BITS +: N_BITS]
//  req_b        in   NUM_REQ*N_BITS    operand 2, same packing
//  resp_valid   out  NUM_REQ           one-hot response valid, to the owner of the result
//  resp_ready   in   NUM_REQ           per-requester response ready
//  resp_data    out  N_BITS            product (num1*num2 mod p); 0 when resp_err=1
//  resp_err     out  1                 qualifies resp_valid: multiplier timed out
//  mult_rst     out  1                 to multiplier rst
//  mult_en      out  1                 to multiplier en
//  mult_num1    out  N_BITS            to multiplier num1, registered, stable through the op
//  mult_num2    out  N_BITS            to multiplier num2, registered, stable through the op
//  mult_product in   N_BITS            from multiplier product
//  mult_done    in   1                 from multiplier done
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//  - state=IDLE, rr_ptr=0, all outputs 0.
//  - mult_rst is combinationally 1 while rst=1.
//  - rst mid-operation abandons the op: no response, no req_ready; granted requester must resubmit.
//  States (all outputs Moore, decoded from registers):
//  - IDLE:
//    - req_ready is combinational: one-hot grant g = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//    - Zero if no valid.
//    - On grant: latch req_a[g]/req_b[g] into mult_num1/2, owner<=g, rr_ptr<=(g+1) mod NUM_REQ, -> CLEAR.
//  - CLEAR: mult_rst=1 for exactly 1 cycle (returns multiplier to its init state) -> START.
//  - START: mult_en=1 for exactly 1 cycle; mult_done ignored (may be stale) -> WAIT, cnt<=0.
//  - WAIT: cnt increments each cycle.
//    - mult_done=1: capture mult_product into resp_data, resp_err<=0, -> RESP.
//    - Else if cnt==TIMEOUT_CYCLES-1: resp_data<=0, resp_err<=1, -> RESP.
//    - mult_done has priority over timeout on the same cycle.
//  - RESP: resp_valid[owner]=1, data/err held stable.
//    - When resp_ready[owner]=1: -> IDLE, resp_valid cleared next cycle.
//    - resp_ready of non-owners ignored.
//  Timing and ordering:
//  - No new grant until RESP completes: one op in flight, req_ready=0 outside IDLE.
//  - Nominal latency with the Barrett multiplier: accept at cycle t, resp_valid at t+8.
//  - Back-to-back: the next grant can occur the cycle after the RESP handshake.
//  - rr_ptr wraps NUM_REQ-1 -> 0.
//  - A requester dropping req_valid before grant is legal; it is not granted.
// TESTING
//  - Single request, req0 a=3 b=5 -> req_ready[0] pulse; resp_valid[0] 8 cycles later, resp_data=15, resp_err=0.
//  - req2 a=b=p-1 -> resp_data=1.
//  - req1 a=2^253 b=2 -> resp_data=(2^254 mod p).
//  - All 4 valid continuously from reset, resp_ready=all 1s -> grant order 0,1,2,3,0; each resp to the correct owner.
//  - Backpressure: resp_ready[0]=0 for 5 cycles -> resp_valid[0] and resp_data held; req1 valid not granted until handshake.
//  - Stub mult_done=0 forever -> resp_valid with resp_err=1, resp_data=0 at accept+2+TIMEOUT_CYCLES+1 cycles.
//  - Reset mid-op: rst during WAIT -> next cycle IDLE, all outputs 0, rr_ptr=0, no response.
//  - A later request completes normally.

Source files
------------

// File: rtl/galois_mult_arbiter.sv
// Round-robin arbiter/sequencer sharing one Barrett GF(p) multiplier between NUM_REQ requesters.
// One operation in flight: grant -> clear multiplier -> start -> wait for done/timeout -> respond.
module galois_mult_arbiter #(
  parameter int N_BITS         = 254,
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*N_BITS-1:0] req_a,
  input  logic [NUM_REQ*N_BITS-1:0] req_b,
  output logic [NUM_REQ-1:0]        resp_valid,
  input  logic [NUM_REQ-1:0]        resp_ready,
  output logic [N_BITS-1:0]         resp_data,
  output logic                      resp_err,
  output logic                      mult_rst,
  output logic                      mult_en,
  output logic [N_BITS-1:0]         mult_num1,
  output logic [N_BITS-1:0]         mult_num2,
  input  logic [N_BITS-1:0]         mult_product,
  input  logic                      mult_done
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_START,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [PW-1:0]     r_rr_ptr;
  logic [PW-1:0]     r_owner;
  logic [PW-1:0]     w_gnt_idx;
  logic              w_gnt_found;
  logic [CW-1:0]     r_cnt;
  logic [N_BITS-1:0] r_num1;
  logic [N_BITS-1:0] r_num2;
  logic [N_BITS-1:0] r_data;
  logic              r_err;
  logic              w_accept;
  logic              w_timeout;
  logic              w_resp_hs;

  // (base + k) mod NUM_REQ without relying on NUM_REQ being a power of two
  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] base, input int unsigned k);
    logic [31:0] s;
    s = 32'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return s[PW-1:0];
  endfunction

  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!w_gnt_found && req_valid[wrap_inc(r_rr_ptr, k)]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = wrap_inc(r_rr_ptr, k);
      end
    end
  end

  assign w_accept  = (r_state == S_IDLE) && w_gnt_found && !rst;
  assign w_timeout = (r_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign w_resp_hs = (r_state == S_RESP) && resp_ready[r_owner];

  always_comb begin
    req_ready = '0;
    if (w_accept) req_ready[w_gnt_idx] = 1'b1;
  end

  always_comb begin
    resp_valid = '0;
    if (r_state == S_RESP) resp_valid[r_owner] = 1'b1;
  end

  assign resp_data = r_data;
  assign resp_err  = r_err;
  assign mult_rst  = rst || (r_state == S_CLEAR);
  assign mult_en   = (r_state == S_START);
  assign mult_num1 = r_num1;
  assign mult_num2 = r_num2;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_next = S_CLEAR;
      S_CLEAR: w_next = S_START;
      S_START: w_next = S_WAIT;
      S_WAIT:  if (mult_done || w_timeout) w_next = S_RESP;
      S_RESP:  if (w_resp_hs) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
      r_owner  <= '0;
      r_num1   <= '0;
      r_num2   <= '0;
      r_cnt    <= '0;
      r_data   <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_num1   <= req_a[w_gnt_idx*N_BITS +: N_BITS];
        r_num2   <= req_b[w_gnt_idx*N_BITS +: N_BITS];
        r_owner  <= w_gnt_idx;
        r_rr_ptr <= wrap_inc(w_gnt_idx, 1);
      end
      if (r_state == S_START)     r_cnt <= '0;
      else if (r_state == S_WAIT) r_cnt <= r_cnt + 1'b1;
      // done wins over timeout when both land on the same cycle
      if (r_state == S_WAIT) begin
        if (mult_done) begin
          r_data <= mult_product;
          r_err  <= 1'b0;
        end else if (w_timeout) begin
          r_data <= '0;
          r_err  <= 1'b1;
        end
      end
    end
  end

endmodule
